// File: rtl/bus_pkg.sv
//-----------------------------------------------------------------------------
// bus_pkg
//
// Shared types and defaults for the phased on-chip bus responder.
//   resp_state_t        : responder FSM states (WAIT is only reachable when
//                         the design is built with RESP_WAIT_EN defined)
//   DEF_ADDR_W/DATA_W   : default address / data widths
//   DEF_NUM_REGS        : default number of implemented registers
//   RESP_OK / RESP_ERR  : encodings of the completion error flag
//-----------------------------------------------------------------------------
package bus_pkg;

  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_NUM_REGS = 12;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_PHASE = 3'd1,
    DATA_PHASE = 3'd2,
    WAIT       = 3'd3,
    RESP       = 3'd4
  } resp_state_t;

endpackage : bus_pkg

// File: rtl/bus_if.sv
//-----------------------------------------------------------------------------
// bus_if
//
// Handshake and data signals between the arbiter (master side) and a
// responder (slave side) of the phased on-chip bus.
//   valid      : initiator holds high for the whole transaction
//   write      : 1 = write, 0 = read (meaningful in the address phase)
//   addr       : register index (meaningful in the address phase)
//   write_data : write payload (meaningful in the data phase)
//   ready      : one-cycle completion pulse from the responder
//   read_data  : read payload, non-zero only with ready on a good read
//   err        : completion error flag, valid with ready
//   busy       : responder is inside a transaction
//-----------------------------------------------------------------------------
interface bus_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              ready;
  logic [DATA_W-1:0] read_data;
  logic              err;
  logic              busy;

  modport master (
    output valid, write, addr, write_data,
    input  ready, read_data, err, busy
  );

  modport slave (
    input  valid, write, addr, write_data,
    output ready, read_data, err, busy
  );

endinterface : bus_if

// File: rtl/bus_regfile.sv
//-----------------------------------------------------------------------------
// bus_regfile
//
// NUM_REGS x DATA_W register bank behind the bus responder.
//   clk      : clock, writes on rising edge
//   reset    : asynchronous active-low clear of every register
//   we_i     : write enable
//   waddr_i  : write index (indices >= NUM_REGS are ignored)
//   wdata_i  : write data
//   raddr_i  : read index (combinational read port)
//   rdata_o  : read data, 0 for indices >= NUM_REGS
//-----------------------------------------------------------------------------
module bus_regfile
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: this bank is built from flops, not a RAM macro, so it can take the
  // asynchronous clear; a clear loop over a real memory would not map to RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (waddr_i == ADDR_W'(i)) begin
          regs_q[i] <= wdata_i;
        end
      end
    end
  end

  // Decoded read mux; unmatched (out-of-range) indices fall through to 0.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (raddr_i == ADDR_W'(i)) begin
        rdata_o = regs_q[i];
      end
    end
  end

endmodule : bus_regfile

// File: rtl/bus_slave_responder.sv
//-----------------------------------------------------------------------------
// bus_slave_responder
//
// Responder end of the phased on-chip bus. A transaction is a request cycle,
// an address phase, a data phase and a one-cycle completion (RESP) carrying
// read data or an error flag. Serviced against a local bus_regfile.
//
// Ports:
//   clk   : clock, all state updates on rising edge
//   reset : asynchronous active-low reset
//   bus   : bus_if.slave (valid/write/addr/write_data in,
//           ready/read_data/err/busy out)
//
// Parameters: ADDR_W, DATA_W, NUM_REGS (addr >= NUM_REGS completes with err),
//             WAIT_CYCLES (present only with RESP_WAIT_EN).
//
// Build option RESP_WAIT_EN: when defined, DATA_PHASE goes through a WAIT
// state of WAIT_CYCLES cycles before RESP. WAIT_CYCLES = 0 behaves as the
// default build. valid is ignored during WAIT (the write has committed).
//-----------------------------------------------------------------------------
module bus_slave_responder
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
`ifdef RESP_WAIT_EN
  ,
  parameter int unsigned WAIT_CYCLES = 2
`endif
) (
  input  logic clk,
  input  logic reset,
  bus_if.slave bus
);

  resp_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              range_err_q, range_err_d;

  // Registered completion outputs: no combinational path from the bus inputs.
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] resp_src;

`ifdef RESP_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Read value captured in DATA_PHASE and held through WAIT.
  logic [DATA_W-1:0] hold_q, hold_d;
`endif

  bus_regfile #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we_i    (rf_we),
    .waddr_i (addr_q),
    .wdata_i (bus.write_data),
    .raddr_i (addr_q),
    .rdata_o (rf_rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    range_err_d = range_err_q;
    ready_d     = 1'b0;
    err_d       = RESP_OK;
    read_data_d = '0;
    rf_we       = 1'b0;
    resp_src    = rf_rdata;
`ifdef RESP_WAIT_EN
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    if (state_q == WAIT) begin
      resp_src = hold_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = ADDR_PHASE;
        end
      end

      ADDR_PHASE: begin
        addr_d      = bus.addr;
        write_d     = bus.write;
        range_err_d = (32'(bus.addr) >= NUM_REGS);
        state_d     = bus.valid ? DATA_PHASE : IDLE;
      end

      DATA_PHASE: begin
        if (!bus.valid) begin
          // Abort: leaving before the edge means the write never lands.
          state_d = IDLE;
        end else begin
          rf_we = write_q && !range_err_q;
`ifdef RESP_WAIT_EN
          hold_d = rf_rdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
`else
          state_d = RESP;
`endif
        end
      end

`ifdef RESP_WAIT_EN
      WAIT: begin
        // valid is deliberately not sampled: the transaction is committed.
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Load the completion registers on the edge that enters RESP, so they
    // are high for exactly the RESP cycle.
    if (state_d == RESP && state_q != RESP) begin
      ready_d     = 1'b1;
      err_d       = range_err_q ? RESP_ERR : RESP_OK;
      read_data_d = (!write_q && !range_err_q) ? resp_src : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      range_err_q <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= RESP_OK;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      range_err_q <= range_err_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
    end
  end

`ifdef RESP_WAIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end
`endif

  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.read_data = read_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule : bus_slave_responder

// File: doc/bus_slave_responder.md
Name: bus_slave_responder

Overview:
Responder end of the phased on-chip bus. It accepts an initiator transaction as a request, then an address phase, then a data phase, and services it against a local register bank. It returns a one-cycle completion with read data or an error flag. It sits behind the arbiter, which drives the bus_if signals listed under Ports.

Parameters:
ADDR_W, 4, address width
DATA_W, 8, data width; write_data narrower than DATA_W is zero-extended by the initiator
NUM_REGS, 12, implemented registers; addr >= NUM_REGS is an error
WAIT_CYCLES, 2, response wait states; used only when RESP_WAIT_EN is defined

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
valid  in  1  initiator holds high for the whole transaction
write  in  1  1 = write, 0 = read; sampled in address phase
addr  in  ADDR_W  register index; sampled in address phase
write_data  in  DATA_W  sampled in data phase when write=1
ready  out  1  one-cycle completion pulse
read_data  out  DATA_W  valid while ready=1 for reads, else 0
err  out  1  valid with ready; 1 = out-of-range address
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ready, err, busy and read_data all 0; all registers 0.
- States: IDLE, ADDR_PHASE, DATA_PHASE, RESP (plus WAIT when the feature is enabled).
- IDLE: valid=1 -> ADDR_PHASE. Otherwise stay in IDLE.
- ADDR_PHASE: latch addr and write into internal registers; compute range_err = (addr >= NUM_REGS); go to DATA_PHASE.
- DATA_PHASE:
  - Write with no error: register[addr_q] <= write_data at the end of this cycle.
  - Read: capture register[addr_q] into a read holding register.
  - Go to RESP.
- RESP:
  - ready=1 for exactly one cycle; err=range_err.
  - read_data = captured value for a read with no error; otherwise 0.
  - Next state is IDLE.
- Back-to-back: if valid is still 1 in the cycle after RESP, that cycle counts as a new request (IDLE -> ADDR_PHASE). Minimum transaction is 4 cycles, request cycle to ready.
- Abort: valid=0 in ADDR_PHASE or DATA_PHASE -> IDLE next cycle.
  - No register write, no ready pulse.
  - A write is aborted only if valid drops before the DATA_PHASE edge.
- valid=0 during RESP does not cancel the ready pulse.
- Error write: no register changes; err=1 with ready.
- Error read: read_data=0; err=1 with ready.
- Address compare is unsigned. With defaults, addr 12..15 are errors.
- A reset assertion mid-transaction returns to IDLE immediately; outputs clear with no pulse.
- Output timing: ready, err and read_data are registered outputs with no combinational path from inputs. busy is decoded from state.

Optional Feature:
RESP_WAIT_EN
- Defined: DATA_PHASE -> WAIT.
  - WAIT counts WAIT_CYCLES cycles (counter loaded in DATA_PHASE), then goes to RESP. Latency is 4+WAIT_CYCLES cycles.
  - busy stays high during WAIT.
  - valid=0 during WAIT is ignored; the write has already committed.
  - WAIT_CYCLES=0 behaves exactly as undefined.
- Undefined: no WAIT state and no counter; latency is 4 cycles.

Decomposition:
- Package bus_pkg:
  - resp_state_t enum (IDLE, ADDR_PHASE, DATA_PHASE, WAIT, RESP)
  - default ADDR_W, DATA_W and NUM_REGS localparams
  - RESP_OK/RESP_ERR constants
- Sub-module bus_regfile:
  - NUM_REGS x DATA_W registers with asynchronous active-low clear
  - one synchronous write port (we, waddr, wdata) and one combinational read port
  - the responder FSM instantiates it

Test Plan:
- Reset, then write addr=4'hB, data=8'h1A -> ready at cycle 4 with err=0; read addr=4'hB -> read_data=8'h1A, err=0.
- Write addr=4'hD, then read addr=4'hD -> both give err=1; read_data=0; no register changes (full scan reads 0 except the earlier writes).
- Abort: valid drops during ADDR_PHASE of a write of 8'hFF to addr 3 -> no ready pulse; read addr 3 returns 8'h00.
- Back-to-back: four writes to addrs 0..3 with valid held high -> ready pulses 4 cycles apart; read-back matches.
- Reset asserted in DATA_PHASE -> ready, busy and read_data go 0 immediately; all registers read 0 afterwards.
- With RESP_WAIT_EN and WAIT_CYCLES=2 -> ready at cycle 6; dropping valid in WAIT still yields ready and a committed write.
